// File: rtl/mac_result_fifo.sv
// mac_result_fifo
// ---------------
// Show-ahead result FIFO between a MAC stage and its downstream consumer.
// Words are stored bit-exact and delivered strictly in arrival order. The
// oldest stored word is always presented on out_data, and out_data is zero
// whenever the FIFO is empty.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid come only from registered state, so there
// is no combinational path from out_ready to in_ready. There is no
// write-through when full and no bypass when empty: a word written at edge N
// is visible on out_data just after edge N.
//
// Parameters
//   WIDTH  bits per MAC result word (default 18)
//   DEPTH  number of entries; a power of two from 2 to 64 (default 8)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears pointers, count, stall_cnt)
//   in_data    word from the MAC stage
//   in_valid   in_data is valid this cycle
//   in_ready   FIFO can accept a word this cycle (count < DEPTH)
//   out_data   oldest stored word, zero when empty
//   out_valid  out_data holds a stored word (count != 0)
//   out_ready  downstream consumes out_data this cycle
//   count      number of stored words, 0..DEPTH
//   stall_cnt  saturating count of cycles with in_valid=1 and in_ready=0;
//              present only when MAC_FIFO_STALL_CNT_EN is defined
//
// Build option
//   MAC_FIFO_STALL_CNT_EN  adds the stall_cnt port and register.

module mac_result_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef MAC_FIFO_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // count never exceeds DEPTH, so "not full" is the same as count < DEPTH.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign wr_en     = in_valid & in_ready;
  assign rd_en     = out_valid & out_ready;

  // Masking keeps stale array contents (never cleared by reset) invisible.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Storage carries no reset; a write during reset is suppressed so the
  // discarded word cannot leak out later.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef MAC_FIFO_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/mac_result_fifo.md
MAC_RESULT_FIFO -- requirements
Module: mac_result_fifo

Interface
REQ-001 Parameter WIDTH, default 18: bit width of one MAC result word, matching the MAC accumulator output.
REQ-002 Parameter DEPTH, default 8: number of entries; SHALL be a power of two, 2 to 64.
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: reset; one clock; reset is synchronous and active-high.
REQ-005 Port in_data  input  WIDTH: MAC result word from the upstream MAC stage.
REQ-006 Port in_valid  input  1: in_data is valid this cycle.
REQ-007 Port in_ready  output  1: block accepts a word this cycle.
REQ-008 Port out_data  output  WIDTH: oldest stored word (show-ahead).
REQ-009 Port out_valid  output  1: out_data holds a stored word.
REQ-010 Port out_ready  input  1: downstream consumes out_data this cycle.
REQ-011 Port count  output  log2(DEPTH)+1: number of stored words, 0 to DEPTH.
REQ-012 Port stall_cnt  output  16: backpressure stall counter; present only when MAC_FIFO_STALL_CNT_EN is defined.

Function
REQ-013 A write SHALL occur on each edge where in_valid=1 and in_ready=1; in_data is stored at the write pointer.
REQ-014 A read SHALL occur on each edge where out_valid=1 and out_ready=1; the read pointer advances by one.
REQ-015 in_ready SHALL equal (count < DEPTH) and SHALL depend only on registered state, never on out_ready; there is no write-through when full.
REQ-016 out_valid SHALL equal (count != 0) and SHALL depend only on registered state.
REQ-017 out_data SHALL equal the word at the read pointer while out_valid=1, and all-zeros while out_valid=0.
REQ-018 Latency: a word written at edge N SHALL appear on out_data, with out_valid=1, after edge N when the FIFO was empty; there is no same-cycle bypass.
REQ-019 Simultaneous read and write with 0 < count < DEPTH SHALL leave count unchanged and move both pointers.
REQ-020 Write only SHALL increment count by 1; read only SHALL decrement count by 1; neither SHALL leave count unchanged.
REQ-021 Pointers SHALL wrap modulo DEPTH; data order SHALL be strict FIFO across wrap.
REQ-022 in_valid while full SHALL store nothing and change no state other than stall_cnt, if present.
REQ-023 out_ready while empty SHALL change no state.
REQ-024 Words SHALL be stored bit-exact; there is no sign conversion, truncation or saturation.
REQ-025 in_data SHALL be ignored whenever no write occurs.

Reset
REQ-026 When rst=1 at a clock edge, pointers and count SHALL clear to 0, giving in_ready=1, out_valid=0 and out_data=0 after that edge.
REQ-027 Reset SHALL take priority over a simultaneous read or write; a word presented during reset SHALL be discarded.
REQ-028 Storage array contents need not be cleared; REQ-017 guarantees that no stale data is visible.
REQ-029 Reset asserted mid-operation SHALL discard all stored words; after rst falls, the first word written SHALL be the first word read.

Configuration
REQ-030 With macro MAC_FIFO_STALL_CNT_EN defined, the block SHALL include a 16-bit stall_cnt output and register.
REQ-031 The stall_cnt register SHALL increment on each edge with in_valid=1 and in_ready=0, SHALL saturate at 16'hFFFF, and SHALL clear on rst.
REQ-032 Without MAC_FIFO_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then write 18'h00005 with out_ready=0 -> after 1 edge: out_valid=1, out_data=18'h00005, count=1.
REQ-034 Write 8 words 18'h00001..18'h00008 with out_ready=0 -> count=8, in_ready=0. A 9th write of 18'h3FFFF is not stored. Then read 8 words -> 18'h00001..18'h00008 in order, then out_valid=0, out_data=0.
REQ-035 Run continuous write and read for 20 cycles with data 18'h20000+i, starting from count=3 -> count stays 3, output order is preserved across pointer wrap, and no word is lost.
REQ-036 With count=5, assert rst for 1 cycle while in_valid=1 -> count=0, out_valid=0; the next write of 18'h1ABCD reads back as 18'h1ABCD.
REQ-037 MAC_FIFO_STALL_CNT_EN defined: fill to full, then hold in_valid=1 for 10 cycles -> stall_cnt=10. Forced to 16'hFFFE, 3 more stall cycles -> stall_cnt=16'hFFFF.
REQ-038 Empty FIFO with out_ready=1 for 5 cycles -> count stays 0, out_valid=0, pointers unchanged; the next write/read pair returns the written word.
